// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard subsystem.
// Used by the host transmitter and the scan-code receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK_SAMPLE,
        WAIT_IDLE,
        ERROR
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_FIRST_EDGE = 2'b01;
    localparam logic [1:0] ERR_PACKET     = 2'b10;
    localparam logic [1:0] ERR_NO_ACK     = 2'b11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RESP_ACK     = 8'hFA;
    localparam logic [7:0] RESP_RESEND  = 8'hFE;

    // Frame index of the stop bit: data 0-7, parity 8, stop 9.
    localparam logic [3:0] STOP_IDX = 4'd9;

    // PS/2 uses odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pad plus falling-edge detect.
// Idle-high reset so that leaving reset never looks like an edge.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic fe
);

    logic meta;
    logic sync;
    logic prev;

    // Metastability stages followed by one history flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fe    = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, RTS, 11-bit frame).
// Drive-low outputs feed the open-drain pads at the top level.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES     = 6000,
    parameter int FIRST_EDGE_TIMEOUT = 750000,
    parameter int PACKET_TIMEOUT     = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_low,
    output logic       ps2_dat_low,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > FIRST_EDGE_TIMEOUT) ?
                             INHIBIT_CYCLES : FIRST_EDGE_TIMEOUT;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int PW = $clog2(PACKET_TIMEOUT + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES);
    localparam logic [CW-1:0] FE_LAST  = CW'(FIRST_EDGE_TIMEOUT);
    localparam logic [PW-1:0] PKT_LAST = PW'(PACKET_TIMEOUT);

    ps2_state_t    state;
    ps2_state_t    state_n;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pkt_cnt;
    logic [3:0]    bit_idx;
    logic [9:0]    frame;
    logic [1:0]    err_q;
    logic [1:0]    err_n;
    logic          accept;
    logic          in_packet;
    logic          pkt_expired;

    logic clk_s;
    logic clk_fe;
    logic dat_s;
    logic dat_fe_unused;

    ps2_sync_edge u_clk_sync (
        .clock (clock),
        .reset (reset),
        .din   (ps2_clk_i),
        .level (clk_s),
        .fe    (clk_fe)
    );

    ps2_sync_edge u_dat_sync (
        .clock (clock),
        .reset (reset),
        .din   (ps2_dat_i),
        .level (dat_s),
        .fe    (dat_fe_unused)
    );

    assign accept      = (state == IDLE) && cmd_valid;
    assign in_packet   = (state == SEND) || (state == ACK_SAMPLE) ||
                         (state == WAIT_IDLE);
    assign pkt_expired = (pkt_cnt == PKT_LAST);
    assign err_code    = err_q;

    // State register; reset drops back to IDLE and releases both lines.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and line drive; busy is low in the done/error cycle.
    always_comb begin
        state_n     = state;
        err_n       = ERR_NONE;
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        ps2_clk_low = 1'b0;
        ps2_dat_low = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                busy        = 1'b1;
                ps2_clk_low = 1'b1;
                if (cnt == INH_LAST) begin
                    ps2_dat_low = 1'b1;
                    state_n     = RTS;
                end
            end
            RTS: begin
                busy        = 1'b1;
                ps2_dat_low = 1'b1;
                if (clk_fe) begin
                    state_n = SEND;
                end else if (cnt == FE_LAST) begin
                    state_n = ERROR;
                    err_n   = ERR_FIRST_EDGE;
                end
            end
            SEND: begin
                busy        = 1'b1;
                ps2_dat_low = ~frame[bit_idx];
                if (pkt_expired) begin
                    state_n = ERROR;
                    err_n   = ERR_PACKET;
                end else if (clk_fe && bit_idx == STOP_IDX) begin
                    state_n = ACK_SAMPLE;
                end
            end
            ACK_SAMPLE: begin
                busy = 1'b1;
                if (pkt_expired) begin
                    state_n = ERROR;
                    err_n   = ERR_PACKET;
                end else if (dat_s) begin
                    state_n = ERROR;
                    err_n   = ERR_NO_ACK;
                end else begin
                    state_n = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (pkt_expired) begin
                    busy    = 1'b1;
                    state_n = ERROR;
                    err_n   = ERR_PACKET;
                end else if (clk_s && dat_s) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            ERROR: begin
                error   = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Error code clears on accept and is captured on entry to ERROR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= ERR_NONE;
        end else if (accept) begin
            err_q <= ERR_NONE;
        end else if (state_n == ERROR && state != ERROR) begin
            err_q <= err_n;
        end
    end

    // Shared phase counter for inhibit length and first-edge wait.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state != state_n) begin
            cnt <= '0;
        end else if ((state == INHIBIT && cnt != INH_LAST) ||
                     (state == RTS && cnt != FE_LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Packet timer runs from the first device edge until the end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt <= '0;
        end else if (state == RTS) begin
            pkt_cnt <= '0;
        end else if (in_packet && !pkt_expired) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

    // Frame latch and bit pointer advanced by device falling edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame   <= '0;
            bit_idx <= '0;
        end else begin
            if (accept) begin
                frame <= {1'b1, odd_parity(cmd_byte), cmd_byte};
            end
            if (state == RTS) begin
                bit_idx <= '0;
            end else if (state == SEND && clk_fe && bit_idx != STOP_IDX) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device.
// Random command bytes; expected results queued at issue time.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int FET  = 200;
    localparam int PKT  = 2000;
    localparam int HALF = 20;

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;
    localparam int M_STALL  = 3;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [7:0] data;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_low;
    logic       ps2_dat_low;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;

    exp_t       exp_q[$];
    logic [9:0] rx_q[$];

    int nvec    = 0;
    int nfail   = 0;
    int acc_cnt = 0;

    assign ps2_clk_i = dev_clk & ~ps2_clk_low;
    assign ps2_dat_i = dev_dat & ~ps2_dat_low;

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (INH),
        .FIRST_EDGE_TIMEOUT (FET),
        .PACKET_TIMEOUT     (PKT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_byte    (cmd_byte),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_dat_i   (ps2_dat_i),
        .ps2_clk_low (ps2_clk_low),
        .ps2_dat_low (ps2_dat_low),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected outcome of one command from the protocol rules alone.
    function automatic exp_t ref_model(input logic [7:0] b, input int mode);
        exp_t e;
        e.data   = b;
        e.is_err = (mode != M_ACK);
        case (mode)
            M_SILENT: e.code = 2'b01;
            M_STALL:  e.code = 2'b10;
            M_NOACK:  e.code = 2'b11;
            default:  e.code = 2'b00;
        endcase
        return e;
    endfunction

    function automatic logic ref_parity(input logic [7:0] b);
        return (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    endfunction

    // Monitor: every done/error pulse consumes one expected result.
    always @(negedge clock) begin : mon
        exp_t       e;
        logic [9:0] f;
        if (!reset && (done || error)) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_pulse: done=%0b error=%0b, required none",
                         done, error);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_is_error", 32'(error), 32'(e.is_err));
                chk("pulse_is_done", 32'(done), 32'(!e.is_err));
                chk("busy_at_pulse", 32'(busy), 32'd0);
                chk("lines_released", 32'({ps2_clk_low, ps2_dat_low}), 32'd0);
                if (e.is_err) begin
                    chk("err_code", 32'(err_code), 32'(e.code));
                end else if (rx_q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL rx_frame: got none, required byte %0h", e.data);
                end else begin
                    f = rx_q.pop_front();
                    chk("rx_data", 32'(f[7:0]), 32'(e.data));
                    chk("rx_parity", 32'(f[8]), 32'(ref_parity(e.data)));
                    chk("rx_odd_ones", 32'($countones(f[8:0]) % 2), 32'd1);
                    chk("rx_stop", 32'(f[9]), 32'd1);
                end
            end
        end
    end

    // Count accepted commands for the backpressure check.
    always @(posedge clock) begin
        if (!reset && cmd_valid && cmd_ready) begin
            acc_cnt++;
        end
    end

    task automatic issue(input logic [7:0] b);
        int n;
        n = 0;
        while (!cmd_ready && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            nvec++;
            nfail++;
            $display("FAIL ready_wait: got cmd_ready=0, required 1");
        end
        cmd_byte  = b;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Device side: waits for request-to-send, then clocks in a frame.
    task automatic dev_run(input int mode, input bit chk_inh);
        int         inh;
        int         n;
        int         npulse;
        logic [9:0] cap;
        npulse = (mode == M_STALL) ? 5 : 11;
        cap    = '0;
        inh    = 0;
        while (ps2_clk_low && !ps2_dat_low && inh < 1000) begin
            inh++;
            @(negedge clock);
        end
        if (chk_inh) begin
            chk("inhibit_len", 32'(inh), 32'(INH));
            chk("start_bit_clk_low", 32'({ps2_clk_low, ps2_dat_low}), 32'd3);
        end
        n = 0;
        while (!(!ps2_clk_low && ps2_dat_low) && n < 10) begin
            n++;
            @(negedge clock);
        end
        chk("rts_lines", 32'({ps2_clk_low, ps2_dat_low}), 32'd1);
        if (mode == M_SILENT) return;
        repeat ($urandom_range(30, 2)) @(negedge clock);
        for (int k = 0; k < npulse; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            if (k < 10) cap[k] = ps2_dat_i;
            dev_clk = 1'b1;
            if (k == 10) begin
                dev_dat = 1'b1;
                if (mode == M_ACK) rx_q.push_back(cap);
            end
            if (k == 9 && mode == M_ACK) begin
                repeat (HALF / 2) @(negedge clock);
                dev_dat = 1'b0;
                repeat (HALF / 2) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            @(negedge clock);
            n++;
        end
        nvec++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d pending results, required 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_xfer(input logic [7:0] b, input int mode,
                           input bit chk_inh);
        int n;
        exp_q.push_back(ref_model(b, mode));
        issue(b);
        dev_run(mode, chk_inh);
        if (mode == M_SILENT) begin
            n = 0;
            while (!error && n < 400) begin
                @(negedge clock);
                n++;
            end
            nvec++;
            if (n < FET || n > FET + 1) begin
                nfail++;
                $display("FAIL first_edge_latency: got %0d cycles, required %0d..%0d",
                         n, FET, FET + 1);
            end
            repeat (5) @(negedge clock);
            chk("err_code_holds", 32'(err_code), 32'd1);
            chk("ready_after_err", 32'(cmd_ready), 32'd1);
        end
        wait_drain();
        repeat (30) @(negedge clock);
    endtask

    initial begin
        int         base;
        logic [7:0] b;
        logic [7:0] b2;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        reset     = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_lines", 32'({ps2_clk_low, ps2_dat_low}), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        do_xfer(8'hED, M_ACK, 1'b1);
        do_xfer(8'h00, M_ACK, 1'b1);
        do_xfer(8'h01, M_ACK, 1'b1);
        do_xfer(8'($urandom), M_SILENT, 1'b1);
        do_xfer(8'($urandom), M_NOACK, 1'b1);
        do_xfer(8'($urandom), M_STALL, 1'b1);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            do_xfer(b, ($urandom_range(3, 0) == 0) ? M_NOACK : M_ACK, 1'b1);
        end

        issue(8'h00);
        dev_run(M_STALL, 1'b1);
        chk("bit4_driven", 32'(ps2_dat_low), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_release", 32'({ps2_clk_low, ps2_dat_low}), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_err_code", 32'(err_code), 32'd0);
        repeat (10) @(negedge clock);

        b    = 8'($urandom);
        b2   = 8'($urandom);
        base = acc_cnt;
        exp_q.push_back(ref_model(b, M_ACK));
        exp_q.push_back(ref_model(b2, M_ACK));
        cmd_byte  = b;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_byte = b2;
        fork
            dev_run(M_ACK, 1'b1);
            begin
                repeat (100) @(negedge clock);
                chk("no_accept_busy", 32'(acc_cnt - base), 32'd1);
                chk("ready_low_busy", 32'(cmd_ready), 32'd0);
            end
        join
        chk("accept_after_done", 32'(acc_cnt - base), 32'd2);
        cmd_valid = 1'b0;
        dev_run(M_ACK, 1'b0);
        wait_drain();
        repeat (20) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
